pwm_duty_button_conditioner: RTL and testbench

Conditions the two raw duty-adjust push-button inputs and drives the increase/decrease duty inputs of the PWM generator directly downstream. Per button it provides:
- a 2-flop synchronizer
- a stable-count debouncer
- rising-edge pulse generation, so each physical press yields exactly one clean single-cycle step request
- mutual-exclusion rules so the generator never sees an increase and a decrease request in the same cycle

---
 rtl/pwm_duty_button_conditioner.sv | 159 +++++++++++++++
 tb/tb_pwm_duty_button_conditioner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_button_conditioner.sv
// Duty-adjust button conditioner: sync, debounce, press pulses with mutual exclusion.
// Optional auto-repeat of a held button when AUTO_REPEAT_EN is defined.
module pwm_duty_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("pwm_duty_button_conditioner: timing parameters must be >= 2");
    end

    // Bit 0 is the increase button, bit 1 the decrease button.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_nxt;
    logic [1:0]    press;
    logic [1:0]    pulse_nxt;
    logic [CW-1:0] cnt     [2];
    logic [CW-1:0] cnt_nxt [2];

    assign raw = {btn_dec_raw, btn_inc_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_comb begin
        lvl_nxt = lvl;
        for (int i = 0; i < 2; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != lvl[i]) begin
                if (cnt[i] == DB_LAST) begin
                    lvl_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            lvl    <= lvl_nxt;
            cnt[0] <= cnt_nxt[0];
            cnt[1] <= cnt_nxt[1];
        end
    end

    // A press only counts while the other button is low before and after the edge.
    assign press[0] = !lvl[0] && lvl_nxt[0] && !lvl[1] && !lvl_nxt[1];
    assign press[1] = !lvl[1] && lvl_nxt[1] && !lvl[0] && !lvl_nxt[0];

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    rpt_state_t    state;
    rpt_state_t    state_nxt;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_nxt;
    logic          org;
    logic          org_nxt;
    logic [1:0]    rpt_fire;
    logic          hold;

    assign hold = lvl_nxt[org] && !lvl_nxt[~org];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            org     <= 1'b0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_cnt_nxt;
            org     <= org_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rpt_cnt_nxt = rpt_cnt;
        org_nxt     = org;
        rpt_fire    = '0;
        if (|press) begin
            state_nxt   = DELAY;
            rpt_cnt_nxt = '0;
            org_nxt     = press[1];
        end else begin
            case (state)
                DELAY, REPEAT: begin
                    if (!hold) begin
                        state_nxt = IDLE;
                    end else if ((state == DELAY && rpt_cnt == RD_LAST) ||
                                 (state == REPEAT && rpt_cnt == RP_LAST)) begin
                        rpt_fire[org] = 1'b1;
                        rpt_cnt_nxt   = '0;
                        state_nxt     = REPEAT;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign pulse_nxt = press | rpt_fire;
`else
    assign pulse_nxt = press;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            inc_pulse <= pulse_nxt[0];
            dec_pulse <= pulse_nxt[1];
        end
    end

    assign inc_level = lvl[0];
    assign dec_level = lvl[1];

endmodule

// File: tb/tb_pwm_duty_button_conditioner.sv
// Bench for pwm_duty_button_conditioner: window-based reference model plus directed cases.
// Build with +define+AUTO_REPEAT_EN to exercise the auto-repeat variant.
module tb_pwm_duty_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_inc_raw = 1'b0;
    logic btn_dec_raw = 1'b0;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_level;
    logic dec_level;

    pwm_duty_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_inc_raw(btn_inc_raw),
        .btn_dec_raw(btn_dec_raw),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .inc_level  (inc_level),
        .dec_level  (dec_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last D synchronized samples all disagree with it.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl[2];
    bit m_pulse[2];
    bit hist0[$];
    bit hist1[$];
    int cyc = 0;
    bit r_active = 0;
    int r_org = 0;
    int r_t = 0;

    always @(posedge clk or posedge reset) begin
        bit nl[2];
        bit pr[2];
        bit all_diff;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pulse[i] = 0;
            end
            hist0.delete();
            hist1.delete();
            r_active = 0;
        end else begin
            cyc++;
            hist0.push_back(m_s2[0]);
            hist1.push_back(m_s2[1]);
            if (hist0.size() > D) void'(hist0.pop_front());
            if (hist1.size() > D) void'(hist1.pop_front());
            nl[0] = m_lvl[0];
            nl[1] = m_lvl[1];
            if (hist0.size() == D) begin
                all_diff = 1;
                foreach (hist0[k]) if (hist0[k] == m_lvl[0]) all_diff = 0;
                if (all_diff) nl[0] = !m_lvl[0];
            end
            if (hist1.size() == D) begin
                all_diff = 1;
                foreach (hist1[k]) if (hist1[k] == m_lvl[1]) all_diff = 0;
                if (all_diff) nl[1] = !m_lvl[1];
            end
            pr[0] = !m_lvl[0] && nl[0] && !m_lvl[1] && !nl[1];
            pr[1] = !m_lvl[1] && nl[1] && !m_lvl[0] && !nl[0];
            m_pulse[0] = pr[0];
            m_pulse[1] = pr[1];
`ifdef AUTO_REPEAT_EN
            if (pr[0] || pr[1]) begin
                r_active = 1;
                r_org = pr[1] ? 1 : 0;
                r_t = cyc;
            end else if (r_active) begin
                if (!nl[r_org] || nl[1-r_org]) begin
                    r_active = 0;
                end else begin
                    int e;
                    e = cyc - r_t;
                    if (e == RD || (e > RD && (e - RD) % RP == 0)) m_pulse[r_org] = 1;
                end
            end
`endif
            m_lvl[0] = nl[0];
            m_lvl[1] = nl[1];
            m_s2[0] = m_s1[0];
            m_s2[1] = m_s1[1];
            m_s1[0] = btn_inc_raw;
            m_s1[1] = btn_dec_raw;
        end
    end

    always begin
        @(posedge clk);
        #1;
        check("inc_pulse", inc_pulse, m_pulse[0]);
        check("dec_pulse", dec_pulse, m_pulse[1]);
        check("inc_level", inc_level, m_lvl[0]);
        check("dec_level", dec_level, m_lvl[1]);
        check("pulse_exclusive", inc_pulse & dec_pulse, 0);
    end

    // Directed-test monitor: edge counter restarted by each test.
    int ec = 0;
    int inc_n, dec_n, inc_first, inc_last, dec_first, inc_lvl_first, dec_lvl_first, inc_low_n;

    task automatic clr_mon();
        ec = 0; inc_n = 0; dec_n = 0; inc_first = 0; inc_last = 0; dec_first = 0;
        inc_lvl_first = 0; dec_lvl_first = 0; inc_low_n = 0;
    endtask

    always begin
        @(posedge clk);
        ec++;
        #1;
        if (inc_pulse) begin
            inc_n++;
            if (inc_first == 0) inc_first = ec;
            inc_last = ec;
        end
        if (dec_pulse) begin
            dec_n++;
            if (dec_first == 0) dec_first = ec;
        end
        if (inc_level && inc_lvl_first == 0) inc_lvl_first = ec;
        if (dec_level && dec_lvl_first == 0) dec_lvl_first = ec;
        if (!inc_level) inc_low_n++;
    end

    task automatic drive(input bit i, input bit d, input int n);
        btn_inc_raw = i;
        btn_dec_raw = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        drive(0, 0, 12);
        clr_mon();
    endtask

    int inc_rem, dec_rem;

    initial begin
        clr_mon();
        repeat (3) @(negedge clk);
        check("reset_inc_level", inc_level, 0);
        check("reset_inc_pulse", inc_pulse, 0);
        reset = 1'b0;
        settle();

        // Single held press
        drive(1, 0, 20);
`ifdef AUTO_REPEAT_EN
        check("t1_inc_pulses", inc_n, 4);
        check("t1_inc_last", inc_last, 20);
`else
        check("t1_inc_pulses", inc_n, 1);
`endif
        check("t1_inc_first", inc_first, 6);
        check("t1_inc_level_edge", inc_lvl_first, 6);
        check("t1_dec_pulses", dec_n, 0);
        settle();

        // Press bounce on dec
        drive(0, 1, 3); drive(0, 0, 1); drive(0, 1, 3); drive(0, 0, 12);
        check("t2_dec_level_edge", dec_lvl_first, 0);
        check("t2_dec_pulses", dec_n, 0);
        settle();

        // Release bounce on held inc
        drive(1, 0, 10);
        clr_mon();
        drive(0, 0, 3); drive(1, 0, 1); drive(0, 0, 3); drive(1, 0, 12);
        check("t2_inc_level_low_cycles", inc_low_n, 0);
`ifndef AUTO_REPEAT_EN
        check("t2_inc_pulses", inc_n, 0);
`endif
        settle();

        // Simultaneous press
        drive(1, 1, 20);
        check("t3_inc_level_edge", inc_lvl_first, 6);
        check("t3_dec_level_edge", dec_lvl_first, 6);
        check("t3_inc_pulses", inc_n, 0);
        check("t3_dec_pulses", dec_n, 0);
        settle();

        // Press dec while inc is held, then a clean dec press
        drive(1, 0, 10);
        clr_mon();
        drive(1, 1, 12);
        check("t4_dec_level_edge", dec_lvl_first, 6);
        check("t4_dec_blocked", dec_n, 0);
        settle();
        drive(0, 1, 5); drive(0, 0, 10);
        check("t4_dec_pulses", dec_n, 1);
        check("t4_dec_first", dec_first, 6);
        settle();

        // Reset mid-debounce with button held
        drive(1, 0, 3);
        reset = 1'b1;
        #1;
        check("t5_reset_inc_level", inc_level, 0);
        check("t5_reset_inc_pulse", inc_pulse, 0);
        check("t5_reset_dec_level", dec_level, 0);
        check("t5_reset_dec_pulse", dec_pulse, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clr_mon();
        drive(1, 0, 12);
        check("t5_inc_pulses", inc_n, 1);
        check("t5_inc_first", inc_first, 6);
        settle();

`ifdef AUTO_REPEAT_EN
        // Auto-repeat cadence then dec press stops it
        drive(1, 0, 24);
        check("t6_inc_pulses", inc_n, 5);
        check("t6_inc_first", inc_first, 6);
        check("t6_inc_last", inc_last, 23);
        clr_mon();
        drive(1, 1, 20);
        check("t6_stop_after_dec", (inc_last > 6) ? 1 : 0, 0);
        settle();
`endif

        // Randomized run with occasional resets
        inc_rem = 0;
        dec_rem = 0;
        for (int c = 0; c < 4000; c++) begin
            if (inc_rem == 0) begin
                btn_inc_raw = 1'($urandom_range(0, 1));
                inc_rem = $urandom_range(1, 30);
            end
            if (dec_rem == 0) begin
                btn_dec_raw = 1'($urandom_range(0, 1));
                dec_rem = $urandom_range(1, 30);
            end
            inc_rem--;
            dec_rem--;
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            else reset = 1'b0;
            @(negedge clk);
        end
        reset = 1'b0;
        drive(0, 0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
